axi_rd_arb: RTL and testbench
=============================

// Module: axi_rd_arb
// PURPOSE
//  Shares the single AXI read channel (AR/R) of the core between NREQ read requesters: I-cache refill, D-cache refill, PTW.
//  Sits inside the MMU between the requesters and m_axi_ar*/m_axi_r*; one transaction in flight at a time.
//  Sequences each grant through ADDR and DATA phases, routes R beats to the granted requester, flags protocol errors.
// PARAMETERS
//  NREQ  3   number of requesters (index 0 = PTW, 1 = D-cache, 2 = I-cache)
//  AW    64  address width
//  DW    64  data width
// PORTS
//  clk           in   1          clock
//  rst           in   1          synchronous reset, active-low
//  rq_valid      in   NREQ       requester i has a read pending
//  rq_addr       in   NREQ*AW    read address per requester
//  rq_len        in   NREQ*8     AXI burst length-1 per requester
//  rq_ready      out  NREQ       one-cycle grant pulse; request consumed
//  rs_valid      out  NREQ       R beat valid for requester i
//  rs_data       out  DW         R beat data (shared bus)
//  rs_last       out  1          last beat of burst
//  rs_err        out  1          rresp != OKAY on this beat
//  m_axi_arid    out  8          = granted index
//  m_axi_araddr  out  AW         granted address
//  m_axi_arlen   out  8          granted length
//  m_axi_arsize  out  3          constant 3'd3 (8 bytes)
//  m_axi_arburst out  2          constant 2'b01 (INCR)
//  m_axi_arvalid out  1          address valid
//  m_axi_arready in   1          address accepted
//  m_axi_rid     in   8          response id
//  m_axi_rdata   in   DW         response data
//  m_axi_rresp   in   2          response status
//  m_axi_rlast   in   1          last beat
//  m_axi_rvalid  in   1          beat valid
//  m_axi_rready  out  1          beat accepted
//  prot_err      out  1          sticky protocol error
//  gnt_cnt       out  32         total grants issued (wraps at 2^32)
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, rr pointer=0, beat counter=0, prot_err=0, gnt_cnt=0; all valid/ready outputs 0.
//  Reset mid-transaction drops it; no AR/R completion is owed afterwards (reset is system-wide).
//  FSM IDLE: if any rq_valid, pick winner, pulse rq_ready[w] for one cycle, latch id/addr/len, gnt_cnt++, go ADDR.
//   - Winner: round-robin starting at index rr; rr <= w+1 (mod NREQ) on grant.
//  ADDR: m_axi_arvalid=1 with latched fields; held stable until arready; on arvalid&&arready go DATA, beat counter=0.
//   - AR presented the cycle after the grant pulse; minimum grant-to-AR latency 1 cycle.
//  DATA: m_axi_rready=1 (requesters cannot back-pressure); rs_valid[id]=m_axi_rvalid, combinational pass-through.
//   - rs_data/rs_last/rs_err forwarded combinationally; per-beat counter increments on rvalid.
//   - On rvalid&&rlast go IDLE; next grant possible that same IDLE cycle (2-cycle bubble min between ARs).
//  Protocol error (sets sticky prot_err, cleared only by reset):
//   - rid != latched id on any beat; rlast with counter != len; counter == len without rlast.
//   - rvalid while IDLE or ADDR is ignored (rready=0 there) and is not an error.
//  Requester withdrawing rq_valid before grant is legal; granted request is never cancelled.
//  Simultaneous requests in IDLE: exactly one grant per IDLE visit; losers keep rq_valid high.
//  Beat counter 8 bits; len 255 (256 beats) is the max and must not overflow the compare.
// CONFIGURATION
//  AXI_RD_ARB_PRIO_EN defined: fixed priority, lowest index wins (PTW > D-cache > I-cache); rr pointer unused.
//  Not defined: round-robin as above. All other behaviour identical.
// TESTING
//  1 Single req0 addr=0x80001000 len=7 -> rq_ready[0] 1 cycle, AR next cycle id=0 len=7, 8 beats on rs_valid[0], rs_last on 8th.
//  2 All three rq_valid held, RR build -> grants order 0,1,2,0; PRIO build -> 0,0,0 while req0 stays high.
//  3 arready held 0 for 5 cycles -> arvalid/araddr/arlen stable all 5, DATA entered only after handshake.
//  4 Burst len=3 but rlast on beat 2 -> prot_err=1 and stays 1; FSM returns IDLE; next grant proceeds.
//  5 rid=2 while granted id=1 -> prot_err=1; rresp=2'b10 on a beat -> rs_err=1 that beat only.
//  6 rst=0 asserted in DATA mid-burst -> next cycle all outputs 0, state IDLE, gnt_cnt=0, prot_err=0.

Source files
------------

// File: rtl/axi_rd_arb.sv
//------------------------------------------------------------------------------
// Module  : axi_rd_arb
// Brief   : Shares one AXI read channel (AR/R) between NREQ requesters, with one
//           transaction in flight at a time. Define AXI_RD_ARB_PRIO_EN to use
//           fixed priority (lowest index wins); otherwise round-robin is used.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_rd_arb #(
  parameter int NREQ = 3,
  parameter int AW   = 64,
  parameter int DW   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   rq_valid,
  input  logic [NREQ*AW-1:0] rq_addr,
  input  logic [NREQ*8-1:0] rq_len,
  output logic [NREQ-1:0]   rq_ready,
  output logic [NREQ-1:0]   rs_valid,
  output logic [DW-1:0]     rs_data,
  output logic              rs_last,
  output logic              rs_err,
  output logic [7:0]        m_axi_arid,
  output logic [AW-1:0]     m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [7:0]        m_axi_rid,
  input  logic [DW-1:0]     m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              prot_err,
  output logic [31:0]       gnt_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] id_q, id_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [31:0]   gnt_cnt_q, gnt_cnt_d;
  logic          perr_q, perr_d;
  logic          win_vld;
  logic [IW-1:0] win;

`ifdef AXI_RD_ARB_PRIO_EN
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rq_valid[k]) begin
        win_vld = 1'b1;
        win     = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] rr_q, rr_d;
  int            idx;

  // Scan from the pointer upward with wrap; the first pending requester wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!win_vld && rq_valid[idx]) begin
        win_vld = 1'b1;
        win     = IW'(idx);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == S_IDLE && win_vld)
      rr_d = (int'(win) == NREQ - 1) ? '0 : win + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) rr_q <= '0;
    else      rr_q <= rr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      gnt_cnt_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      gnt_cnt_q <= gnt_cnt_d;
      perr_q    <= perr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    gnt_cnt_d = gnt_cnt_q;
    perr_d    = perr_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d   = S_ADDR;
          id_d      = win;
          addr_d    = rq_addr[int'(win)*AW +: AW];
          len_d     = rq_len[int'(win)*8 +: 8];
          gnt_cnt_d = gnt_cnt_q + 32'd1;
        end
      end
      S_ADDR: begin
        if (m_axi_arready) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (m_axi_rvalid) begin
          cnt_d = cnt_q + 8'd1;
          // Compare against len before increment so len=255 never overflows.
          if ((m_axi_rid != 8'(id_q)) ||
              (m_axi_rlast && (cnt_q != len_q)) ||
              (!m_axi_rlast && (cnt_q == len_q)))
            perr_d = 1'b1;
          if (m_axi_rlast)
            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rq_ready[i] = rst && (state_q == S_IDLE) && win_vld && (win == IW'(i));
      rs_valid[i] = (state_q == S_DATA) && m_axi_rvalid && (id_q == IW'(i));
    end
    rs_data       = m_axi_rdata;
    rs_last       = (state_q == S_DATA) && m_axi_rvalid && m_axi_rlast;
    rs_err        = (state_q == S_DATA) && m_axi_rvalid && (m_axi_rresp != 2'b00);
    m_axi_arid    = 8'(id_q);
    m_axi_araddr  = addr_q;
    m_axi_arlen   = len_q;
    m_axi_arsize  = 3'd3;
    m_axi_arburst = 2'b01;
    m_axi_arvalid = (state_q == S_ADDR);
    m_axi_rready  = (state_q == S_DATA);
    prot_err      = perr_q;
    gnt_cnt       = gnt_cnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arb.sv
//------------------------------------------------------------------------------
// Module  : tb_axi_rd_arb
// Brief   : Directed self-checking bench for axi_rd_arb (either arbitration build).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_rd_arb;

  logic          clk;
  logic          rst;
  logic [2:0]    rq_valid;
  logic [191:0]  rq_addr;
  logic [23:0]   rq_len;
  logic [2:0]    rq_ready;
  logic [2:0]    rs_valid;
  logic [63:0]   rs_data;
  logic          rs_last;
  logic          rs_err;
  logic [7:0]    m_axi_arid;
  logic [63:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [7:0]    m_axi_rid;
  logic [63:0]   m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic          prot_err;
  logic [31:0]   gnt_cnt;

  int checks = 0;
  int errors = 0;

  axi_rd_arb #(.NREQ(3), .AW(64), .DW(64)) dut (
    .clk(clk), .rst(rst),
    .rq_valid(rq_valid), .rq_addr(rq_addr), .rq_len(rq_len), .rq_ready(rq_ready),
    .rs_valid(rs_valid), .rs_data(rs_data), .rs_last(rs_last), .rs_err(rs_err),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .prot_err(prot_err), .gnt_cnt(gnt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rq_valid = '0;
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00;
    m_axi_rid = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [63:0] addr, input logic [7:0] len);
    rq_addr[i*64 +: 64] = addr;
    rq_len[i*8 +: 8]    = len;
  endtask

  // Expects a grant to index exp this cycle, then checks AR and completes the handshake.
  task automatic grant(input int exp, input logic [63:0] exp_addr, input logic [7:0] exp_len);
    logic [2:0] oh;
    oh = 3'b001 << exp;
    #1;
    chk("rq_ready", 64'(rq_ready), 64'(oh));
    tick();
    chk("rq_ready_pulse", 64'(rq_ready), 64'd0);
    chk("arvalid", 64'(m_axi_arvalid), 64'd1);
    chk("arid", 64'(m_axi_arid), 64'(exp));
    chk("araddr", m_axi_araddr, exp_addr);
    chk("arlen", 64'(m_axi_arlen), 64'(exp_len));
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    chk("rready", 64'(m_axi_rready), 64'd1);
    chk("arvalid_drop", 64'(m_axi_arvalid), 64'd0);
  endtask

  task automatic beat(input int exp_id, input logic [7:0] rid, input logic last,
                      input logic [1:0] resp, input logic [63:0] data);
    logic [2:0] oh;
    oh = 3'b001 << exp_id;
    m_axi_rvalid = 1'b1;
    m_axi_rid    = rid;
    m_axi_rlast  = last;
    m_axi_rresp  = resp;
    m_axi_rdata  = data;
    #1;
    chk("rs_valid", 64'(rs_valid), 64'(oh));
    chk("rs_data", rs_data, data);
    chk("rs_last", 64'(rs_last), 64'(last));
    chk("rs_err", 64'(rs_err), 64'(resp != 2'b00));
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
  endtask

  int exp_order[4];

  initial begin
    rq_addr = '0;
    rq_len = '0;
    m_axi_rdata = '0;
    do_reset();

    chk("rst_rq_ready", 64'(rq_ready), 64'd0);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_rready", 64'(m_axi_rready), 64'd0);
    chk("rst_prot_err", 64'(prot_err), 64'd0);
    chk("rst_gnt_cnt", 64'(gnt_cnt), 64'd0);
    chk("arsize", 64'(m_axi_arsize), 64'd3);
    chk("arburst", 64'(m_axi_arburst), 64'd1);

    // Single 8-beat burst from requester 0
    set_req(0, 64'h8000_1000, 8'd7);
    rq_valid = 3'b001;
    grant(0, 64'h8000_1000, 8'd7);
    rq_valid = 3'b000;
    for (int b = 0; b < 8; b++)
      beat(0, 8'd0, (b == 7), 2'b00, 64'h100 + 64'(b));
    chk("t1_idle_rready", 64'(m_axi_rready), 64'd0);
    chk("t1_prot_err", 64'(prot_err), 64'd0);
    chk("t1_gnt_cnt", 64'(gnt_cnt), 64'd1);

    // Maximum-length burst: 256 beats
    set_req(0, 64'hDEAD_0000, 8'd255);
    rq_valid = 3'b001;
    grant(0, 64'hDEAD_0000, 8'd255);
    rq_valid = 3'b000;
    for (int b = 0; b < 256; b++)
      beat(0, 8'd0, (b == 255), 2'b00, 64'h5A00 + 64'(b));
    chk("len255_prot_err", 64'(prot_err), 64'd0);
    chk("len255_idle", 64'(m_axi_rready), 64'd0);
    chk("len255_gnt_cnt", 64'(gnt_cnt), 64'd2);

    // Three requesters held high
    do_reset();
`ifdef AXI_RD_ARB_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0};
`endif
    set_req(0, 64'h1000, 8'd0);
    set_req(1, 64'h2000, 8'd0);
    set_req(2, 64'h3000, 8'd0);
    rq_valid = 3'b111;
    for (int g = 0; g < 4; g++) begin
      grant(exp_order[g], 64'h1000 * 64'(exp_order[g] + 1), 8'd0);
      beat(exp_order[g], 8'(exp_order[g]), 1'b1, 2'b00, 64'hA0 + 64'(g));
    end
    rq_valid = 3'b000;
    chk("t2_gnt_cnt", 64'(gnt_cnt), 64'd4);
    chk("t2_prot_err", 64'(prot_err), 64'd0);

    // AR stalled for five cycles, then a burst with one SLVERR beat
    set_req(1, 64'h1234_5678_9ABC_DEF0, 8'd3);
    rq_valid = 3'b010;
    #1;
    chk("t3_rq_ready", 64'(rq_ready), 64'b010);
    tick();
    rq_valid = 3'b000;
    for (int c = 0; c < 5; c++) begin
      chk("t3_arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("t3_araddr", m_axi_araddr, 64'h1234_5678_9ABC_DEF0);
      chk("t3_arlen", 64'(m_axi_arlen), 64'd3);
      chk("t3_rready", 64'(m_axi_rready), 64'd0);
      tick();
    end
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    chk("t3_data", 64'(m_axi_rready), 64'd1);
    for (int b = 0; b < 4; b++)
      beat(1, 8'd1, (b == 3), (b == 1) ? 2'b10 : 2'b00, 64'hC0 + 64'(b));
    chk("t3_prot_err", 64'(prot_err), 64'd0);

    // Response id mismatch
    set_req(1, 64'h4000, 8'd0);
    rq_valid = 3'b010;
    grant(1, 64'h4000, 8'd0);
    rq_valid = 3'b000;
    beat(1, 8'd2, 1'b1, 2'b00, 64'h77);
    chk("t5_prot_err", 64'(prot_err), 64'd1);

    // Reset in the middle of a burst
    set_req(2, 64'h5000, 8'd7);
    rq_valid = 3'b100;
    grant(2, 64'h5000, 8'd7);
    rq_valid = 3'b000;
    beat(2, 8'd2, 1'b0, 2'b00, 64'h1);
    beat(2, 8'd2, 1'b0, 2'b00, 64'h2);
    rst = 1'b0;
    m_axi_rvalid = 1'b1;
    m_axi_rid = 8'd2;
    tick();
    chk("t6_rs_valid", 64'(rs_valid), 64'd0);
    chk("t6_rready", 64'(m_axi_rready), 64'd0);
    chk("t6_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("t6_rq_ready", 64'(rq_ready), 64'd0);
    chk("t6_prot_err", 64'(prot_err), 64'd0);
    chk("t6_gnt_cnt", 64'(gnt_cnt), 64'd0);
    m_axi_rvalid = 1'b0;
    rst = 1'b1;

    // Early rlast
    set_req(2, 64'h6000, 8'd3);
    rq_valid = 3'b100;
    grant(2, 64'h6000, 8'd3);
    rq_valid = 3'b000;
    beat(2, 8'd2, 1'b0, 2'b00, 64'h10);
    beat(2, 8'd2, 1'b0, 2'b00, 64'h11);
    chk("t4_pre_err", 64'(prot_err), 64'd0);
    beat(2, 8'd2, 1'b1, 2'b00, 64'h12);
    chk("t4_prot_err", 64'(prot_err), 64'd1);
    chk("t4_idle", 64'(m_axi_rready), 64'd0);
    set_req(0, 64'h7000, 8'd0);
    rq_valid = 3'b001;
    grant(0, 64'h7000, 8'd0);
    rq_valid = 3'b000;
    beat(0, 8'd0, 1'b1, 2'b00, 64'h13);
    chk("t4_sticky", 64'(prot_err), 64'd1);
    chk("t4_gnt_cnt", 64'(gnt_cnt), 64'd2);

    // Counter reaches len without rlast
    do_reset();
    set_req(0, 64'h8000, 8'd1);
    rq_valid = 3'b001;
    grant(0, 64'h8000, 8'd1);
    rq_valid = 3'b000;
    beat(0, 8'd0, 1'b0, 2'b00, 64'h20);
    chk("t7_pre_err", 64'(prot_err), 64'd0);
    beat(0, 8'd0, 1'b0, 2'b00, 64'h21);
    chk("t7_prot_err", 64'(prot_err), 64'd1);
    beat(0, 8'd0, 1'b1, 2'b00, 64'h22);
    chk("t7_idle", 64'(m_axi_rready), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
